// File: rtl/card_match.sv
// card_match: pick detection, pair comparison, reveal/match masks and score for the 4x4 memory game.
// Define CARD_MATCH_TWO_PLAYER_EN to add alternating players with per-player scores.
module card_match #(
  parameter int NUM_CARDS   = 16,
  parameter int VAL_W       = 4,
  parameter int SHOW_CYCLES = 25000000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       select,
  input  logic [3:0]                 cursor,
  input  logic [NUM_CARDS*VAL_W-1:0] cards,
  output logic [NUM_CARDS-1:0]       revealed,
  output logic [NUM_CARDS-1:0]       matched,
  output logic [3:0]                 first_idx,
  output logic                       first_valid,
  output logic                       match_pulse,
  output logic                       miss_pulse,
  output logic [3:0]                 pairs,
  output logic [7:0]                 turns,
  output logic                       game_over
`ifdef CARD_MATCH_TWO_PLAYER_EN
  ,
  output logic                       player,
  output logic [3:0]                 score0,
  output logic [3:0]                 score1
`endif
);

  localparam int TIMER_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(SHOW_CYCLES - 1);
  localparam logic [3:0] PAIRS_ALL = 4'(NUM_CARDS / 2);

  typedef enum logic [2:0] {
    IDLE,
    ONE,
    CHECK,
    SHOW,
    DONE
  } state_t;

  // One-hot mask of a card index; an index past the board yields an empty mask.
  function automatic logic [NUM_CARDS-1:0] card_mask(input logic [3:0] idx);
    logic [NUM_CARDS-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_CARDS; i++) begin
      if (idx == 4'(i)) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [VAL_W-1:0] card_val(input logic [NUM_CARDS*VAL_W-1:0] c,
                                                input logic [3:0] idx);
    logic [VAL_W-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_CARDS; i++) begin
      if (idx == 4'(i)) v = c[VAL_W*i +: VAL_W];
    end
    return v;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] x);
    return (x == 8'hFF) ? x : x + 8'd1;
  endfunction

  state_t               state, state_d;
  logic                 select_q;
  logic [3:0]           second_idx, second_idx_d, first_idx_d;
  logic                 first_valid_d, match_pulse_d, miss_pulse_d;
  logic [NUM_CARDS-1:0] revealed_d, matched_d;
  logic [NUM_CARDS-1:0] cur_mask, first_mask, second_mask;
  logic [3:0]           pairs_d;
  logic [7:0]           turns_d;
  logic [TIMER_W-1:0]   timer, timer_d;
  logic                 pick, accept, same;
`ifdef CARD_MATCH_TWO_PLAYER_EN
  logic                 player_d;
  logic [3:0]           score0_d, score1_d;
`endif

  assign cur_mask    = card_mask(cursor);
  assign first_mask  = card_mask(first_idx);
  assign second_mask = card_mask(second_idx);
  assign pick        = select & ~select_q;
  assign accept      = pick & (|cur_mask) & ~(|(revealed & cur_mask));
  // Values are read live, so the compare sees whatever cards holds during CHECK.
  assign same        = (card_val(cards, first_idx) == card_val(cards, second_idx));
  assign game_over   = (state == DONE);

  always_comb begin
    state_d       = state;
    revealed_d    = revealed;
    matched_d     = matched;
    first_idx_d   = first_idx;
    first_valid_d = first_valid;
    second_idx_d  = second_idx;
    match_pulse_d = 1'b0;
    miss_pulse_d  = 1'b0;
    pairs_d       = pairs;
    turns_d       = turns;
    timer_d       = timer;
`ifdef CARD_MATCH_TWO_PLAYER_EN
    player_d      = player;
    score0_d      = score0;
    score1_d      = score1;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          revealed_d    = revealed | cur_mask;
          first_idx_d   = cursor;
          first_valid_d = 1'b1;
          state_d       = ONE;
        end
      end
      ONE: begin
        if (accept) begin
          revealed_d   = revealed | cur_mask;
          second_idx_d = cursor;
          state_d      = CHECK;
        end
      end
      CHECK: begin
        turns_d       = sat_inc8(turns);
        first_valid_d = 1'b0;
        if (same) begin
          matched_d     = matched | first_mask | second_mask;
          match_pulse_d = 1'b1;
          pairs_d       = pairs + 4'd1;
`ifdef CARD_MATCH_TWO_PLAYER_EN
          if (player) score1_d = score1 + 4'd1;
          else        score0_d = score0 + 4'd1;
`endif
          state_d       = (pairs_d == PAIRS_ALL) ? DONE : IDLE;
        end else begin
          miss_pulse_d = 1'b1;
          timer_d      = TIMER_LOAD;
          state_d      = SHOW;
        end
      end
      SHOW: begin
        // Timer reaches zero on the last face-up cycle; the pair hides on the next edge.
        if (timer == '0) begin
          revealed_d = revealed & ~(first_mask | second_mask);
          state_d    = IDLE;
`ifdef CARD_MATCH_TWO_PLAYER_EN
          player_d   = ~player;
`endif
        end else begin
          timer_d = timer - 1'b1;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      select_q    <= 1'b0;
      revealed    <= '0;
      matched     <= '0;
      first_idx   <= '0;
      first_valid <= 1'b0;
      second_idx  <= '0;
      match_pulse <= 1'b0;
      miss_pulse  <= 1'b0;
      pairs       <= '0;
      turns       <= '0;
      timer       <= '0;
`ifdef CARD_MATCH_TWO_PLAYER_EN
      player      <= 1'b0;
      score0      <= '0;
      score1      <= '0;
`endif
    end else begin
      state       <= state_d;
      select_q    <= select;
      revealed    <= revealed_d;
      matched     <= matched_d;
      first_idx   <= first_idx_d;
      first_valid <= first_valid_d;
      second_idx  <= second_idx_d;
      match_pulse <= match_pulse_d;
      miss_pulse  <= miss_pulse_d;
      pairs       <= pairs_d;
      turns       <= turns_d;
      timer       <= timer_d;
`ifdef CARD_MATCH_TWO_PLAYER_EN
      player      <= player_d;
      score0      <= score0_d;
      score1      <= score1_d;
`endif
    end
  end

endmodule

// File: tb/tb_card_match.sv
// Self-checking bench for card_match: directed game scenarios plus randomized games
// checked against a turn-level model of the memory-game rules.
module tb_card_match;

  localparam int SHOW = 4;
  localparam logic [63:0] DEF_CARDS = 64'h7766554433221100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        select = 1'b0;
  logic [3:0]  cursor = 4'd0;
  logic [63:0] cards = DEF_CARDS;
  logic [15:0] revealed, matched;
  logic [3:0]  first_idx, pairs;
  logic        first_valid, match_pulse, miss_pulse, game_over;
  logic [7:0]  turns;
  logic [47:0] obs;
`ifdef CARD_MATCH_TWO_PLAYER_EN
  logic        player;
  logic [3:0]  score0, score1;
  logic [8:0]  pobs;
  assign pobs = {player, score0, score1};
`endif

  int checks = 0;
  int errors = 0;

  assign obs = {revealed, matched, first_valid, match_pulse, miss_pulse, pairs, turns, game_over};

  card_match #(.NUM_CARDS(16), .VAL_W(4), .SHOW_CYCLES(SHOW)) dut (
    .clk(clk), .rst(rst), .select(select), .cursor(cursor), .cards(cards),
    .revealed(revealed), .matched(matched), .first_idx(first_idx),
    .first_valid(first_valid), .match_pulse(match_pulse), .miss_pulse(miss_pulse),
    .pairs(pairs), .turns(turns), .game_over(game_over)
`ifdef CARD_MATCH_TWO_PLAYER_EN
    , .player(player), .score0(score0), .score1(score1)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pick(input int idx);
    cursor = 4'(idx);
    select = 1'b1;
    tick();
    select = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b0; select = 1'b0; cursor = 4'd0; cards = DEF_CARDS;
    tick(); tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; select = 1'b1; cursor = 4'd3;
    tick(); tick();
    select = 1'b0;
    checks++; if (obs !== 48'h0 || first_idx !== 4'd0) begin errors++; $display("FAIL reset_state got %h/%h want 0/0", obs, first_idx); end
`ifdef CARD_MATCH_TWO_PLAYER_EN
    checks++; if (pobs !== 9'h0) begin errors++; $display("FAIL reset_player got %h want 0", pobs); end
`endif
    rst = 1'b1;
    tick();
    checks++; if (obs !== 48'h0) begin errors++; $display("FAIL reset_release got %h want 0", obs); end
  endtask

  task automatic test_match();
    do_reset();
    pick(0);
    checks++; if (obs !== {16'h0001, 16'h0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0} || first_idx !== 4'd0)
      begin errors++; $display("FAIL match_first got %h idx %0d", obs, first_idx); end
    pick(1);
    checks++; if (obs !== {16'h0003, 16'h0003, 1'b0, 1'b1, 1'b0, 4'd1, 8'd1, 1'b0})
      begin errors++; $display("FAIL match_result got %h want %h", obs, {16'h0003, 16'h0003, 1'b0, 1'b1, 1'b0, 4'd1, 8'd1, 1'b0}); end
    tick();
    checks++; if (obs !== {16'h0003, 16'h0003, 1'b0, 1'b0, 1'b0, 4'd1, 8'd1, 1'b0})
      begin errors++; $display("FAIL match_pulse_width got %h", obs); end
  endtask

  task automatic test_miss();
    do_reset();
    pick(0);
    pick(2);
    checks++; if (obs !== {16'h0005, 16'h0, 1'b0, 1'b0, 1'b1, 4'd0, 8'd1, 1'b0})
      begin errors++; $display("FAIL miss_result got %h", obs); end
    for (int i = 0; i < SHOW - 1; i++) begin
      tick();
      checks++; if (obs !== {16'h0005, 16'h0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd1, 1'b0})
        begin errors++; $display("FAIL miss_show%0d got %h", i, obs); end
    end
    tick();
    checks++; if (obs !== {16'h0000, 16'h0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd1, 1'b0})
      begin errors++; $display("FAIL miss_hide got %h", obs); end
  endtask

  task automatic test_hold();
    do_reset();
    cursor = 4'd5; select = 1'b1;
    tick();
    cursor = 4'd6;
    tick(); tick();
    select = 1'b0;
    tick();
    checks++; if (obs !== {16'h0020, 16'h0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0} || first_idx !== 4'd5)
      begin errors++; $display("FAIL hold_single got %h idx %0d", obs, first_idx); end
    pick(5);
    checks++; if (obs !== {16'h0020, 16'h0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0} || first_idx !== 4'd5)
      begin errors++; $display("FAIL hold_repick got %h idx %0d", obs, first_idx); end
    pick(6);
    checks++; if (obs !== {16'h0060, 16'h0, 1'b0, 1'b0, 1'b1, 4'd0, 8'd1, 1'b0})
      begin errors++; $display("FAIL hold_miss got %h", obs); end
    pick(7);
    checks++; if (obs !== {16'h0060, 16'h0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd1, 1'b0})
      begin errors++; $display("FAIL show_pick_dropped got %h", obs); end
    tick(); tick();
    checks++; if (obs !== {16'h0000, 16'h0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd1, 1'b0})
      begin errors++; $display("FAIL show_end got %h", obs); end
    pick(7);
    checks++; if (obs !== {16'h0080, 16'h0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd1, 1'b0} || first_idx !== 4'd7)
      begin errors++; $display("FAIL after_show_pick got %h idx %0d", obs, first_idx); end
  endtask

  task automatic test_cards_change();
    do_reset();
    pick(0);
    cursor = 4'd2; select = 1'b1;
    tick();
    cards = 64'h7766554433221000;
    tick();
    select = 1'b0;
    checks++; if (obs !== {16'h0005, 16'h0005, 1'b0, 1'b1, 1'b0, 4'd1, 8'd1, 1'b0})
      begin errors++; $display("FAIL cards_live_compare got %h", obs); end
    tick();
    cards = DEF_CARDS;
  endtask

  task automatic test_game_over();
    do_reset();
    for (int p = 0; p < 8; p++) begin
      pick(2 * p);
      pick(2 * p + 1);
      checks++; if (match_pulse !== 1'b1 || pairs !== 4'(p + 1) || turns !== 8'(p + 1))
        begin errors++; $display("FAIL game_pair%0d got mp %b pairs %0d turns %0d", p, match_pulse, pairs, turns); end
    end
    checks++; if (obs !== {16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b0, 4'd8, 8'd8, 1'b1})
      begin errors++; $display("FAIL game_over got %h", obs); end
    pick(3);
    pick(4);
    checks++; if (obs !== {16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, 4'd8, 8'd8, 1'b1})
      begin errors++; $display("FAIL done_ignores got %h", obs); end
  endtask

  task automatic test_reset_show();
    do_reset();
    pick(9);
    pick(2);
    checks++; if (obs !== {16'h0204, 16'h0, 1'b0, 1'b0, 1'b1, 4'd0, 8'd1, 1'b0})
      begin errors++; $display("FAIL rshow_miss got %h", obs); end
    tick();
    rst = 1'b0;
    tick();
    checks++; if (obs !== 48'h0 || first_idx !== 4'd0)
      begin errors++; $display("FAIL rshow_cleared got %h idx %0d", obs, first_idx); end
    rst = 1'b1;
    repeat (SHOW + 2) tick();
    pick(4);
    checks++; if (obs !== {16'h0010, 16'h0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0} || first_idx !== 4'd4)
      begin errors++; $display("FAIL rshow_idle_pick got %h idx %0d", obs, first_idx); end
  endtask

`ifdef CARD_MATCH_TWO_PLAYER_EN
  task automatic test_two_player();
    do_reset();
    pick(0);
    pick(2);
    checks++; if (pobs !== 9'h000) begin errors++; $display("FAIL tp_during_show got %h want 000", pobs); end
    repeat (SHOW) tick();
    checks++; if (pobs !== {1'b1, 4'd0, 4'd0}) begin errors++; $display("FAIL tp_toggle got %h", pobs); end
    pick(0);
    pick(1);
    checks++; if (pobs !== {1'b1, 4'd0, 4'd1} || pairs !== 4'd1) begin errors++; $display("FAIL tp_score1 got %h pairs %0d", pobs, pairs); end
    pick(6);
    pick(8);
    repeat (SHOW) tick();
    pick(8);
    pick(9);
    checks++; if (pobs !== {1'b0, 4'd1, 4'd1} || pairs !== 4'd2) begin errors++; $display("FAIL tp_score0 got %h pairs %0d", pobs, pairs); end
  endtask
`endif

  task automatic test_random();
    int vals[16];
    logic [15:0] mm, pm;
    logic [47:0] e;
    int np, nt, a, b, tmp, j;
    bit hit;
    int pl, s0, s1;
    do_reset();
    for (int i = 0; i < 16; i++) vals[i] = i / 2;
    for (int i = 15; i > 0; i--) begin
      j = $urandom_range(i, 0);
      tmp = vals[i]; vals[i] = vals[j]; vals[j] = tmp;
    end
    for (int i = 0; i < 16; i++) cards[4*i +: 4] = 4'(vals[i]);
    mm = '0; np = 0; nt = 0; pl = 0; s0 = 0; s1 = 0;
    for (int t = 0; t < 90 && np < 8; t++) begin
      do a = $urandom_range(15, 0); while (mm[a]);
      do b = $urandom_range(15, 0); while (mm[b] || b == a);
      pick(a);
      e = {mm | (16'd1 << a), mm, 1'b1, 1'b0, 1'b0, 4'(np), 8'(nt), 1'b0};
      checks++; if (obs !== e || first_idx !== 4'(a)) begin errors++; $display("FAIL rnd_first t%0d got %h want %h", t, obs, e); end
      pick(a);
      checks++; if (obs !== e) begin errors++; $display("FAIL rnd_repick t%0d got %h want %h", t, obs, e); end
      pick(b);
      nt++;
      pm = (16'd1 << a) | (16'd1 << b);
      hit = (vals[a] == vals[b]);
      if (hit) begin
        mm = mm | pm; np++;
        if (pl == 1) s1++; else s0++;
        e = {mm, mm, 1'b0, 1'b1, 1'b0, 4'(np), 8'(nt), np == 8};
      end else begin
        e = {mm | pm, mm, 1'b0, 1'b0, 1'b1, 4'(np), 8'(nt), 1'b0};
      end
      checks++; if (obs !== e) begin errors++; $display("FAIL rnd_result t%0d got %h want %h", t, obs, e); end
      if (!hit) begin
        repeat (SHOW) tick();
        pl = 1 - pl;
        e = {mm, mm, 1'b0, 1'b0, 1'b0, 4'(np), 8'(nt), 1'b0};
        checks++; if (obs !== e) begin errors++; $display("FAIL rnd_hide t%0d got %h want %h", t, obs, e); end
      end
`ifdef CARD_MATCH_TWO_PLAYER_EN
      checks++; if (pobs !== {1'(pl), 4'(s0), 4'(s1)}) begin errors++; $display("FAIL rnd_players t%0d got %h", t, pobs); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_match();
    test_miss();
    test_hold();
    test_cards_change();
    test_game_over();
    test_reset_show();
`ifdef CARD_MATCH_TWO_PLAYER_EN
    test_two_player();
`endif
    for (int g = 0; g < 3; g++) test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/card_match.md
Name: card_match

Overview:
- Game-logic stage directly downstream of the cursor/select block (`move`) on the 4x4 memory-game board.
- Consumes the cursor position, the select button and the 16 card values (4 bits each).
- Tracks first and second picks, compares them, and records matched pairs.
- Holds a mismatched pair face-up for a fixed time, then hides it.
- Produces the face-up/matched masks and the score/turn counts for the display stage.

Parameters:
- NUM_CARDS, 16, number of cards on the board (must be even; cursor width is 4).
- VAL_W, 4, bits per card value.
- SHOW_CYCLES, 25000000, cycles a mismatched pair stays face-up (benches override to 4; minimum 1).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous active-low reset (rst=0 sampled at a rising edge clears all state).
- select  input  1  select button level from the cursor stage; a pick is its rising edge.
- cursor  input  4  index of the card under the cursor (0..NUM_CARDS-1).
- cards  input  NUM_CARDS*VAL_W  packed card values; card i occupies [VAL_W*i+VAL_W-1 : VAL_W*i].
- revealed  output  NUM_CARDS  face-up mask: matched cards plus cards currently picked.
- matched  output  NUM_CARDS  permanently matched cards.
- first_idx  output  4  index of the pending first pick.
- first_valid  output  1  a first pick is pending.
- match_pulse  output  1  one-cycle pulse when a pair matches.
- miss_pulse  output  1  one-cycle pulse when a pair mismatches.
- pairs  output  4  matched pair count, 0..NUM_CARDS/2.
- turns  output  8  completed turns (pairs compared), saturating at 255.
- game_over  output  1  high while all pairs are matched.

Behaviour:
- Reset values: every output is 0; FSM enters IDLE; internal select_q=0; timer=0.
- Pick detection:
  - pick = select & ~select_q; select_q is the previous sample of select.
  - A held button yields exactly one pick.
- A pick is accepted only in IDLE or ONE, and only if `revealed[cursor]`=0. Otherwise it is silently dropped (no state change).
- FSM:
  - IDLE: an accepted pick sets `revealed[cursor]`, `first_idx`=cursor, `first_valid`=1, and moves to ONE.
  - ONE: an accepted pick sets `revealed[cursor]`, latches second_idx, and moves to CHECK. Re-picking the first card is rejected by the revealed rule.
  - CHECK (exactly 1 cycle): compare the VAL_W-bit values of `first_idx` and second_idx; `turns`++ (saturating); `first_valid`=0.
    - Equal: set both `matched` bits; `match_pulse`=1 for the next cycle; `pairs`++; go to DONE if the new `pairs`=NUM_CARDS/2, else IDLE.
    - Not equal: `miss_pulse`=1 for the next cycle; timer loaded with SHOW_CYCLES-1; go to SHOW.
  - SHOW: timer decrements each cycle. When it is 0, clear the two picked `revealed` bits (`matched` bits untouched) and go to IDLE. Both cards are therefore face-up for exactly SHOW_CYCLES cycles in SHOW.
  - DONE: `game_over`=1; all picks ignored; left only by reset.
- Latency:
  - A pick sampled at edge k is visible on `revealed` after edge k.
  - The second pick at edge m gives its match/miss result visible after edge m+1.
- Picks arriving in CHECK or SHOW are dropped, not queued.
- `cards` changing mid-turn: the compare uses the values present during the CHECK cycle.
- A cursor value >= NUM_CARDS is treated as an invalid pick and dropped.
- Reset mid-operation (any state, including SHOW with the timer running) returns to the reset values on that edge.

Optional Feature:
- Macro: CARD_MATCH_TWO_PLAYER_EN.
- Defined:
  - Adds output `player` (1 bit, reset 0) and outputs `score0`/`score1` (4 bits each, reset 0).
  - A match increments the current player's score; the player keeps the turn.
  - A mismatch toggles `player` on the SHOW->IDLE transition.
  - `pairs` still equals score0+score1.
- Not defined: ports `player`, `score0`, `score1` are absent; single-player behaviour only.

Test Plan:
- Setup for all scenarios: rst=0 for 2 edges, then rst=1; cards=64'h7766554433221100; SHOW_CYCLES=4.
- Pick 0, then pick 1 -> after CHECK: `match_pulse` 1 cycle, `matched`=16'h0003, `revealed`=16'h0003, `pairs`=1, `turns`=1, state IDLE.
- Pick 0, then pick 2 -> `miss_pulse` 1 cycle, `revealed`=16'h0005 for 4 cycles then 16'h0000, `turns`=1, `pairs`=0.
- Hold select high 3 cycles on cursor=5 -> one pick only: `first_valid`=1, `first_idx`=5, `revealed`=16'h0020. Picking 5 again and picking during SHOW -> no state change.
- Match all 8 adjacent pairs -> `pairs`=8, `turns`=8, `matched`=16'hFFFF, `game_over`=1; further picks ignored.
- rst=0 during SHOW after a 0/2 mismatch -> next cycle all outputs 0, `revealed`=16'h0000. With CARD_MATCH_TWO_PLAYER_EN: miss toggles `player` 0->1 after SHOW; a subsequent match gives `score1`=1.
